// File: rtl/cache_memory_arbiter.sv
// Arbitrates one word-wide memory port between the I-cache and D-cache line engines,
// sequencing LINE_WORDS beats per granted line fill or write-back.
module cache_memory_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_data_valid,
  output logic [31:0] ic_data,
  output logic        ic_ready,
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic        dc_wdata_accept,
  output logic        dc_data_valid,
  output logic [31:0] dc_data,
  output logic        dc_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W  = CNT_WIDTH + 2;
  localparam int BASE_W = 32 - OFF_W;

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;
  typedef enum logic {SRC_IC, SRC_DC} src_t;

  state_t              state, state_next;
  src_t                grant, last_grant, pick;
  logic                we;
  logic [BASE_W-1:0]   base;
  logic [CNT_WIDTH-1:0] beat;
  logic                start;
  logic                last_beat;
  logic                beat_ack;
  logic                read_ack;

  // Offset bits inside the line are replaced by the beat counter.
  logic unused_offset;
  assign unused_offset = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0]};

  assign last_beat = (beat == CNT_WIDTH'(LINE_WORDS - 1));
  assign beat_ack  = (state == SERVE) && mem_ack;
  assign read_ack  = beat_ack && !we;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next      = state;
    pick            = SRC_IC;
    start           = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    dc_wdata_accept = 1'b0;
    case (state)
      IDLE: begin
        if (ic_req || dc_req) begin
          start      = 1'b1;
          state_next = SERVE;
          // On a tie the side that did not win last time goes first.
          pick = (dc_req && (!ic_req || last_grant == SRC_IC)) ? SRC_DC : SRC_IC;
        end
      end
      SERVE: begin
        mem_req  = 1'b1;
        mem_we   = we;
        mem_addr = {base, beat, 2'b00};
        if (grant == SRC_DC && we) begin
          mem_wdata       = dc_wdata;
          dc_wdata_accept = mem_ack;
        end
        if (mem_ack && last_beat) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= '0;
      base          <= '0;
      we            <= 1'b0;
      grant         <= SRC_IC;
      last_grant    <= SRC_DC;
      ic_data_valid <= 1'b0;
      dc_data_valid <= 1'b0;
      ic_ready      <= 1'b0;
      dc_ready      <= 1'b0;
      ic_data       <= '0;
      dc_data       <= '0;
    end else begin
      state         <= state_next;
      ic_data_valid <= read_ack && (grant == SRC_IC);
      dc_data_valid <= read_ack && (grant == SRC_DC);
      ic_ready      <= beat_ack && last_beat && (grant == SRC_IC);
      dc_ready      <= beat_ack && last_beat && (grant == SRC_DC);
      if (start) begin
        grant      <= pick;
        last_grant <= pick;
        we         <= (pick == SRC_DC) && dc_we;
        base       <= (pick == SRC_DC) ? dc_addr[31:OFF_W] : ic_addr[31:OFF_W];
        beat       <= '0;
      end else if (beat_ack && !last_beat) begin
        beat <= beat + CNT_WIDTH'(1);
      end
      if (read_ack && grant == SRC_IC) ic_data <= mem_rdata;
      if (read_ack && grant == SRC_DC) dc_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_memory_arbiter.sv
// Scoreboard bench for cache_memory_arbiter: directed requests push expected beats,
// words and READY pulses; a negedge monitor pops and compares as the DUT presents them.
module tb_cache_memory_arbiter;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, dc_req, dc_we;
  logic [31:0] ic_addr, dc_addr, dc_wdata;
  logic        ic_data_valid, ic_ready, dc_wdata_accept, dc_data_valid, dc_ready;
  logic [31:0] ic_data, dc_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cache_memory_arbiter #(.LINE_WORDS(LW), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data_valid(ic_data_valid),
    .ic_data(ic_data), .ic_ready(ic_ready),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wdata_accept(dc_wdata_accept), .dc_data_valid(dc_data_valid),
    .dc_data(dc_data), .dc_ready(dc_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} beat_t;
  typedef struct {bit is_dc; bit fill;} ready_t;

  beat_t       beat_q[$];
  logic [31:0] ic_q[$];
  logic [31:0] dc_q[$];
  ready_t      ready_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int req_cycles, acked, stall_cycles, accepts;
  int ack_mode = 0;
  int stall_beat, stall_len, stall_used;
  int wb_idx = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] wb_word(input int k);
    return 32'hD00D_0000 + 32'(k) * 32'h0101_0011;
  endfunction

  assign mem_rdata = mem_ack ? mem_model(mem_addr) : 32'hBAD0_0000;
  assign dc_wdata  = wb_word(wb_idx);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_line(input bit is_dc, input bit we, input logic [31:0] addr);
    logic [31:0] base;
    beat_t b;
    ready_t r;
    base = {addr[31:5], 5'b0};
    for (int k = 0; k < LW; k++) begin
      b.addr  = base + 32'(k * 4);
      b.we    = we;
      b.wdata = we ? wb_word(k) : 32'h0;
      beat_q.push_back(b);
      if (!we) begin
        if (is_dc) dc_q.push_back(mem_model(b.addr));
        else       ic_q.push_back(mem_model(b.addr));
      end
    end
    r.is_dc = is_dc;
    r.fill  = !we;
    ready_q.push_back(r);
  endtask

  task automatic flush();
    beat_q.delete(); ic_q.delete(); dc_q.delete(); ready_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    flush();
  endtask

  task automatic ic_requester(input logic [31:0] addr);
    int n;
    ic_addr = addr; ic_req = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ic_ready && n < 300);
    if (!ic_ready) begin
      checks++; errors++;
      $display("FAIL ic_timeout: no IC_READY after %0d cycles", n);
    end
    @(posedge clk); #1 ic_req = 1'b0;
  endtask

  task automatic dc_requester(input logic [31:0] addr, input logic we);
    int n;
    dc_addr = addr; dc_we = we; dc_req = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!dc_ready && n < 300);
    if (!dc_ready) begin
      checks++; errors++;
      $display("FAIL dc_timeout: no DC_READY after %0d cycles", n);
    end
    @(posedge clk); #1 dc_req = 1'b0;
  endtask

  // Memory responder: decides MEM_ACK for the coming cycle just after each edge.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: mem_ack = ~mem_ack;
        default: begin
          if (mem_req && mem_addr[4:2] == 3'(stall_beat) && stall_used < stall_len) begin
            mem_ack = 1'b0;
            stall_used++;
          end else begin
            mem_ack = 1'b1;
          end
        end
      endcase
    end
  end

  // Write-back source: advance to the next word once the current one is accepted.
  initial begin
    bit acc_now;
    forever begin
      @(negedge clk); acc_now = dc_wdata_accept;
      @(posedge clk); #1;
      if (acc_now) wb_idx++;
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t  h;
    ready_t r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_req) begin
          req_cycles++;
          if (beat_q.size() == 0) begin
            check("mem_req_unexpected", 32'(mem_req), 32'h0);
          end else begin
            h = beat_q[0];
            check("mem_addr", mem_addr, h.addr);
            check("mem_we", 32'(mem_we), 32'(h.we));
            check("mem_wdata", mem_wdata, h.wdata);
            check("dc_wdata_accept", 32'(dc_wdata_accept), 32'(mem_ack && h.we));
            if (mem_ack) begin
              void'(beat_q.pop_front());
              acked++;
            end else begin
              stall_cycles++;
            end
          end
        end else if (dc_wdata_accept) begin
          check("accept_without_req", 32'(dc_wdata_accept), 32'h0);
        end
        if (dc_wdata_accept) accepts++;
        if (ic_data_valid) begin
          if (ic_q.size() == 0) check("ic_valid_unexpected", 32'(ic_data_valid), 32'h0);
          else                  check("ic_data", ic_data, ic_q.pop_front());
        end
        if (dc_data_valid) begin
          if (dc_q.size() == 0) check("dc_valid_unexpected", 32'(dc_data_valid), 32'h0);
          else                  check("dc_data", dc_data, dc_q.pop_front());
        end
        if (ic_ready || dc_ready) begin
          if (ready_q.size() == 0) begin
            check("ready_unexpected", 32'({dc_ready, ic_ready}), 32'h0);
          end else begin
            r = ready_q.pop_front();
            check("ready_side", 32'({dc_ready, ic_ready}), r.is_dc ? 32'h2 : 32'h1);
            check("ready_with_last_valid",
                  32'(r.is_dc ? dc_data_valid : ic_data_valid), 32'(r.fill));
            check("ready_mem_req_low", 32'(mem_req), 32'h0);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ic_addr = '0; dc_addr = '0; dc_we = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_valids", 32'({ic_data_valid, dc_data_valid}), 32'h0);
    check("rst_readys", 32'({ic_ready, dc_ready}), 32'h0);
    check("rst_accept", 32'(dc_wdata_accept), 32'h0);
    check("rst_ic_data", ic_data, 32'h0);
    check("rst_dc_data", dc_data, 32'h0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 1: zero-wait I-cache fill from an unaligned address
    ack_mode = 0; req_cycles = 0; acked = 0;
    expect_line(1'b0, 1'b0, 32'h0000_0104);
    fork
      ic_requester(32'h0000_0104);
      begin
        @(negedge clk); check("t1_idle_no_req", 32'(mem_req), 32'h0);
        @(negedge clk); check("t1_req_latency", 32'(mem_req), 32'h1);
      end
      begin
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!ic_ready && k < 100);
        check("t1_ready_latency", 32'(k), 32'(LW + 2));
      end
    join
    check("t1_req_cycles", 32'(req_cycles), 32'(LW));
    check("t1_acked", 32'(acked), 32'(LW));
    check("t1_dc_data_idle", dc_data, 32'h0);

    // 2: simultaneous requests after reset, then IC re-requests while DC waits
    do_reset();
    @(posedge clk); #1;
    expect_line(1'b0, 1'b0, 32'h0000_0400);
    expect_line(1'b1, 1'b0, 32'h0000_0800);
    expect_line(1'b0, 1'b0, 32'h0000_0440);
    fork
      begin
        ic_requester(32'h0000_0400);
        ic_requester(32'h0000_0440);
      end
      dc_requester(32'h0000_0800, 1'b0);
    join

    // 3: D-cache write-back, ack every second cycle
    ack_mode = 1; wb_idx = 0; accepts = 0;
    expect_line(1'b1, 1'b1, 32'h0000_2004);
    dc_requester(32'h0000_2004, 1'b1);
    check("t3_accepts", 32'(accepts), 32'(LW));
    check("t3_wb_words_used", 32'(wb_idx), 32'(LW));

    // 4: D-cache fill with beat 2 stalled for three cycles
    ack_mode = 2; stall_beat = 2; stall_len = 3; stall_used = 0; stall_cycles = 0;
    expect_line(1'b1, 1'b0, 32'h0000_3000);
    dc_requester(32'h0000_3000, 1'b0);
    check("t4_stall_cycles", 32'(stall_cycles), 32'h3);

    // 5: reset after three acked beats of an I-cache fill
    ack_mode = 2; stall_beat = 3; stall_len = 1000; stall_used = 0; acked = 0;
    expect_line(1'b0, 1'b0, 32'h0000_0300);
    ic_addr = 32'h0000_0300; ic_req = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(posedge clk); #2; n++; end
      while (!(mem_req && mem_addr[4:2] == 3'd3) && n < 50);
      if (n >= 50) begin
        checks++; errors++;
        $display("FAIL t5_timeout: beat 3 never presented");
      end
    end
    rst = 1'b1; ic_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0; ack_mode = 0;
    flush();
    check("t5_acked_before_rst", 32'(acked), 32'h3);
    @(negedge clk);
    check("t5_mem_req_after_rst", 32'(mem_req), 32'h0);
    check("t5_no_ready", 32'(ic_ready), 32'h0);
    check("t5_no_valid", 32'(ic_data_valid), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    expect_line(1'b0, 1'b0, 32'h0000_0300);
    ic_requester(32'h0000_0300);

    // 6: IC request arrives during a DC fill
    expect_line(1'b1, 1'b0, 32'h0000_5000);
    expect_line(1'b0, 1'b0, 32'h0000_6000);
    fork
      dc_requester(32'h0000_5000, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1 ic_requester(32'h0000_6000);
      end
      begin
        int n, g;
        n = 0;
        do begin @(negedge clk); n++; end while (!dc_ready && n < 300);
        g = 0;
        do begin @(negedge clk); g++; end while (!mem_req && g < 20);
        check("t6_ic_gap", 32'(g), 32'h2);
      end
    join

    repeat (3) @(posedge clk);
    check("end_beat_q", 32'(beat_q.size()), 32'h0);
    check("end_ic_q", 32'(ic_q.size()), 32'h0);
    check("end_dc_q", 32'(dc_q.size()), 32'h0);
    check("end_ready_q", 32'(ready_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
